// File: rtl/gcd_sched_if.sv
// Request/response bundle for the shared GCD engine: two operand requesters and one tagged
// result channel, plus the engine busy flag.
interface gcd_sched_if #(
   parameter int unsigned W = 8
);
   logic         req0_valid;
   logic [W-1:0] req0_a;
   logic [W-1:0] req0_b;
   logic         req0_ready;
   logic         req1_valid;
   logic [W-1:0] req1_a;
   logic [W-1:0] req1_b;
   logic         req1_ready;
   logic         resp_valid;
   logic [W-1:0] resp_gcd;
   logic         resp_id;
   logic         resp_ready;
   logic         busy;

   modport slave (
      input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready,
      output req0_ready, req1_ready, resp_valid, resp_gcd, resp_id, busy
   );

   modport master (
      output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready,
      input  req0_ready, req1_ready, resp_valid, resp_gcd, resp_id, busy
   );
endinterface

// File: rtl/gcd_sched.sv
// Two-requester GCD engine: round-robin admission into a subtract-based Euclid datapath,
// one pair in flight at a time, result returned tagged with the requester id.
module gcd_sched #(
   parameter int unsigned W = 8
) (
   input logic        clk,
   input logic        rst_n,
   gcd_sched_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e       state_q, state_d;
   logic [W-1:0] x_q, x_d;
   logic [W-1:0] y_q, y_d;
   logic         id_q, id_d;
   logic         ptr_q, ptr_d;
   logic [W-1:0] resp_gcd_q, resp_gcd_d;
   logic         resp_id_q, resp_id_d;
   logic         resp_valid_q, resp_valid_d;
   logic         busy_q, busy_d;

   logic grant0, grant1, idle;

   // A lone requester wins outright; under contention the pointer decides.
   assign grant0 = bus.req0_valid & (~bus.req1_valid | ~ptr_q);
   assign grant1 = bus.req1_valid & (~bus.req0_valid | ptr_q);
   assign idle   = (state_q == StIdle);

   assign bus.req0_ready = idle & rst_n & grant0;
   assign bus.req1_ready = idle & rst_n & grant1;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_gcd   = resp_gcd_q;
   assign bus.resp_id    = resp_id_q;
   assign bus.busy       = busy_q;

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      id_d       = id_q;
      ptr_d      = ptr_q;
      resp_gcd_d = resp_gcd_q;
      resp_id_d  = resp_id_q;
      case (state_q)
         StIdle: begin
            if (bus.req0_valid && bus.req0_ready) begin
               x_d     = bus.req0_a;
               y_d     = bus.req0_b;
               id_d    = 1'b0;
               ptr_d   = 1'b1;
               state_d = StCalc;
            end else if (bus.req1_valid && bus.req1_ready) begin
               x_d     = bus.req1_a;
               y_d     = bus.req1_b;
               id_d    = 1'b1;
               ptr_d   = 1'b0;
               state_d = StCalc;
            end
         end
         StCalc: begin
            // Larger operand is always the minuend, so no underflow.
            if (y_q == '0 || x_q == y_q) begin
               resp_gcd_d = x_q;
               resp_id_d  = id_q;
               state_d    = StDone;
            end else if (x_q == '0) begin
               resp_gcd_d = y_q;
               resp_id_d  = id_q;
               state_d    = StDone;
            end else if (x_q > y_q) begin
               x_d = x_q - y_q;
            end else begin
               y_d = y_q - x_q;
            end
         end
         StDone: begin
            if (bus.resp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      resp_valid_d = (state_d == StDone);
      busy_d       = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         x_q          <= '0;
         y_q          <= '0;
         id_q         <= 1'b0;
         ptr_q        <= 1'b0;
         resp_gcd_q   <= '0;
         resp_id_q    <= 1'b0;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         id_q         <= id_d;
         ptr_q        <= ptr_d;
         resp_gcd_q   <= resp_gcd_d;
         resp_id_q    <= resp_id_d;
         resp_valid_q <= resp_valid_d;
         busy_q       <= busy_d;
      end
   end

endmodule
